polar64_tx_serializer: RTL and testbench

Serialises 64-bit polar codewords from `polar64_crc16_encoder` onto a 1-bit valid/ready stream for the channel model or line interface. It sits directly downstream of the encoder. It captures each codeword on the encoder's one-cycle `done` pulse, buffers one frame ahead so back-to-back encodes are not lost, and shifts bits out under downstream backpressure with frame delimiters and a frame counter.

---
 rtl/polar64_pkg.sv | 20 ++
 rtl/polar64_tx_buf.sv | 104 ++++++++++
 rtl/polar64_tx_serializer.sv | 146 ++++++++++++++
 tb/tb_polar64_tx_serializer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/polar64_pkg.sv
// polar64_pkg
//   Constants and types shared by the polar64 transmit path.
//   CW_W      : codeword width in bits.
//   SYNC_W    : sync-word width in bits.
//   SYNC_WORD : frame-sync pattern, sent MSB-first ahead of each codeword
//               when POLAR64_TX_SYNC_EN is defined.
//   tx_state_e: serializer FSM states.
package polar64_pkg;

  localparam int CW_W   = 64;
  localparam int SYNC_W = 8;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2
  } tx_state_e;

endpackage

// File: rtl/polar64_tx_buf.sv
// polar64_tx_buf
//   Two-slot codeword store for the serializer. The shift register (SR)
//   holds the frame being sent and the pending register (PR) holds the next
//   one. This block also decides whether a newly offered codeword is loaded
//   or dropped.
//   Ports:
//     clk, rst_n    clock; synchronous active-low reset
//     cw_valid      a new codeword is offered this cycle
//     codeword      the offered codeword
//     shift         one codeword bit is transferred this cycle
//     frame_done    the last codeword bit of SR is transferred this cycle
//     sr_bit        the SR bit currently presented, in transmit order
//     sr_full       SR holds a frame
//     pr_full       PR holds a frame
//     start         a new frame enters SR on this edge
//     drop          the offered codeword is discarded (both slots busy)
module polar64_tx_buf
  import polar64_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cw_valid,
  input  logic [CW_W-1:0] codeword,
  input  logic            shift,
  input  logic            frame_done,
  output logic            sr_bit,
  output logic            sr_full,
  output logic            pr_full,
  output logic            start,
  output logic            drop
);

  logic [CW_W-1:0] sr;
  logic [CW_W-1:0] pr;
  logic            load_sr_new;
  logic            load_pr_new;
  logic            reload;

  // Slot decision for an offered codeword, by (frame_done, pr_full) while
  // SR is busy:
  //   0,0 -> PR           0,1 -> drop
  //   1,0 -> straight into SR, because the slot is freed on this edge and
  //          the frame then starts without a bubble
  //   1,1 -> PR moves to SR and the new word refills PR
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    load_sr_new = 1'b0;
    load_pr_new = 1'b0;
    drop        = 1'b0;
    reload      = frame_done && pr_full;
    if (cw_valid) begin
      if (!sr_full || (frame_done && !pr_full)) begin
        load_sr_new = 1'b1;
      end else if (!pr_full || frame_done) begin
        load_pr_new = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
    start = load_sr_new || reload;
  end

  // The SR shifts so that the outgoing bit always sits at one fixed end.
  // Vacated positions fill with zeros, so ser_bit idles low.
  assign sr_bit = MSB_FIRST ? sr[CW_W-1] : sr[0];

  // NOTE: SR and PR are plain flops rather than a RAM, so they are reset
  // together with their full flags. This keeps the presented bit at 0 out
  // of reset and leaves no stale data that could be seen later.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      pr      <= '0;
      sr_full <= 1'b0;
      pr_full <= 1'b0;
    end else begin
      if (reload) begin
        sr <= pr;
      end else if (load_sr_new) begin
        sr <= codeword;
      end else if (shift) begin
        sr <= MSB_FIRST ? {sr[CW_W-2:0], 1'b0} : {1'b0, sr[CW_W-1:1]};
      end

      if (start) begin
        sr_full <= 1'b1;
      end else if (frame_done) begin
        sr_full <= 1'b0;
      end

      if (load_pr_new) begin
        pr      <= codeword;
        pr_full <= 1'b1;
      end else if (reload) begin
        pr_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/polar64_tx_serializer.sv
// polar64_tx_serializer
//   Serialises 64-bit polar codewords captured on the encoder's done pulse
//   onto a 1-bit valid/ready stream. The block buffers one frame ahead,
//   marks each frame with sof/eof, counts completed frames, and flags
//   dropped codewords.
//   Optional feature: define POLAR64_TX_SYNC_EN to send the 8-bit sync word
//   (SYNC_WORD, MSB-first) before every codeword. ser_sof then marks sync
//   bit 7.
//   Parameters: MSB_FIRST (1: codeword[63] first), FCNT_W (frame counter width)
//   Ports:
//     clk, rst_n          clock; synchronous active-low reset
//     cw_valid, codeword  one-cycle codeword capture from the encoder
//     ser_ready           downstream accepts the current bit
//     ser_valid, ser_bit  serial stream
//     ser_sof, ser_eof    first bit / last codeword bit of a frame
//     busy                SR or PR holds a frame
//     overflow, clr_ovf   sticky drop flag and its clear (a set wins)
//     frame_cnt           frames fully transferred, wrapping
module polar64_tx_serializer
  import polar64_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cw_valid,
  input  logic [CW_W-1:0]   codeword,
  input  logic              ser_ready,
  output logic              ser_valid,
  output logic              ser_bit,
  output logic              ser_sof,
  output logic              ser_eof,
  output logic              busy,
  output logic              overflow,
  input  logic              clr_ovf,
  output logic [FCNT_W-1:0] frame_cnt
);

`ifdef POLAR64_TX_SYNC_EN
  localparam tx_state_e FIRST_ST = ST_SYNC;
  localparam logic [2:0] SYNC_MSB = 3'(SYNC_W - 1);
  logic [2:0] sync_cnt;
`else
  localparam tx_state_e FIRST_ST = ST_DATA;
`endif

  tx_state_e  state;
  logic [5:0] bit_cnt;
  logic       sr_bit;
  logic       sr_full;
  logic       pr_full;
  logic       start;
  logic       drop;
  logic       xfer;
  logic       data_xfer;
  logic       frame_done;

  assign ser_valid  = (state != ST_IDLE);
  assign xfer       = ser_valid && ser_ready;
  assign data_xfer  = xfer && (state == ST_DATA);
  assign frame_done = data_xfer && (bit_cnt == 6'd63);

  polar64_tx_buf #(
    .MSB_FIRST (MSB_FIRST)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .cw_valid   (cw_valid),
    .codeword   (codeword),
    .shift      (data_xfer),
    .frame_done (frame_done),
    .sr_bit     (sr_bit),
    .sr_full    (sr_full),
    .pr_full    (pr_full),
    .start      (start),
    .drop       (drop)
  );

  // The counters advance only on a transfer. 6'd63 + 1 and 3'd7 + 1 wrap to
  // 0, which is the start value the next frame or phase needs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
`ifdef POLAR64_TX_SYNC_EN
      sync_cnt  <= '0;
`endif
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end

      if (frame_done) begin
        frame_cnt <= frame_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state <= FIRST_ST;
          end
        end
`ifdef POLAR64_TX_SYNC_EN
        ST_SYNC: begin
          if (xfer) begin
            sync_cnt <= sync_cnt + 3'd1;
            if (sync_cnt == SYNC_MSB) begin
              state <= ST_DATA;
            end
          end
        end
`endif
        ST_DATA: begin
          if (xfer) begin
            bit_cnt <= bit_cnt + 6'd1;
            // A reload from PR on this edge starts the next frame without a
            // bubble.
            if (bit_cnt == 6'd63) begin
              state <= start ? FIRST_ST : ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The stream outputs decode registered state only. They therefore hold
  // still for as long as ser_ready is low.
`ifdef POLAR64_TX_SYNC_EN
  assign ser_sof = (state == ST_SYNC) && (sync_cnt == 3'd0);
  assign ser_bit = (state == ST_SYNC) ? SYNC_WORD[SYNC_MSB - sync_cnt]
                                      : ((state == ST_DATA) && sr_bit);
`else
  assign ser_sof = (state == ST_DATA) && (bit_cnt == 6'd0);
  assign ser_bit = (state == ST_DATA) && sr_bit;
`endif
  assign ser_eof = (state == ST_DATA) && (bit_cnt == 6'd63);
  assign busy    = sr_full || pr_full;

endmodule

// File: tb/tb_polar64_tx_serializer.sv
// tb_polar64_tx_serializer
//   Randomised self-checking bench. The reference model keeps the expected
//   serial stream as a queue of (bit, sof, eof) entries that is built when a
//   codeword is accepted. It also tracks how many frames are outstanding, the
//   overflow flag and the frame count, all derived from the acceptance and
//   transfer rules of the serializer.
module tb_polar64_tx_serializer;

  localparam bit MSB_FIRST = 1'b1;
  localparam int FCNT_W    = 16;
`ifdef POLAR64_TX_SYNC_EN
  localparam bit SYNC_ON = 1'b1;
`else
  localparam bit SYNC_ON = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              cw_valid;
  logic [63:0]       codeword;
  logic              ser_ready;
  logic              ser_valid;
  logic              ser_bit;
  logic              ser_sof;
  logic              ser_eof;
  logic              busy;
  logic              overflow;
  logic              clr_ovf;
  logic [FCNT_W-1:0] frame_cnt;

  polar64_tx_serializer #(
    .MSB_FIRST (MSB_FIRST),
    .FCNT_W    (FCNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cw_valid  (cw_valid),
    .codeword  (codeword),
    .ser_ready (ser_ready),
    .ser_valid (ser_valid),
    .ser_bit   (ser_bit),
    .ser_sof   (ser_sof),
    .ser_eof   (ser_eof),
    .busy      (busy),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic sof;
    logic eof;
  } sbit_t;

  sbit_t             exp_q[$];
  int                frames_out;
  logic              m_ovf;
  logic [FCNT_W-1:0] m_fcnt;
  int                n_cmp;
  int                n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected transmit order of one accepted codeword.
  task automatic push_frame(input logic [63:0] cw);
    logic [7:0] sw;
    sw = 8'hA5;
    if (SYNC_ON) begin
      for (int i = 0; i < 8; i++) exp_q.push_back('{sw[7-i], (i == 0), 1'b0});
    end
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back('{cw[MSB_FIRST ? 63 - i : i], (!SYNC_ON && i == 0), (i == 63)});
    end
  endtask

  // One clock cycle, entered and left at a falling edge. The task drives the
  // inputs, checks the outputs the DUT presents in this cycle, and then
  // applies the model's view of what the next rising edge does.
  task automatic step(input logic v, input logic [63:0] cw, input logic rdy,
                      input logic clr, input logic rst);
    logic exp_v, xfer, last, accept;
    cw_valid  = v;
    codeword  = cw;
    ser_ready = rdy;
    clr_ovf   = clr;
    rst_n     = ~rst;
    #1;
    exp_v = (exp_q.size() != 0);
    check("ser_valid", ser_valid, exp_v);
    if (exp_v) begin
      check("ser_bit", ser_bit, exp_q[0].b);
      check("ser_sof", ser_sof, exp_q[0].sof);
      check("ser_eof", ser_eof, exp_q[0].eof);
    end
    check("busy", busy, frames_out != 0);
    check("overflow", overflow, m_ovf);
    check("frame_cnt", frame_cnt, m_fcnt);
    if (rst) begin
      exp_q.delete();
      frames_out = 0;
      m_ovf      = 1'b0;
      m_fcnt     = '0;
    end else begin
      xfer   = exp_v && rdy;
      last   = xfer && exp_q[0].eof;
      accept = (frames_out < 2) || last;
      if (xfer) void'(exp_q.pop_front());
      if (last) begin
        frames_out--;
        m_fcnt++;
      end
      if (v && accept) begin
        push_frame(cw);
        frames_out++;
      end
      if (v && !accept) m_ovf = 1'b1;
      else if (clr)     m_ovf = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 64'h0, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) idle(1'b1);
    check("drain_done", ser_valid, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] cw_a, cw_b, cw_c;
    logic        found;
    n_cmp = 0; n_err = 0;
    frames_out = 0; m_ovf = 1'b0; m_fcnt = '0;
    rst_n = 1'b0; cw_valid = 1'b0; codeword = '0; ser_ready = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, with cw_valid asserted during reset to confirm it is ignored.
    step(1'b1, 64'hDEAD_BEEF_0000_1111, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset at bit 30 while PR is full.
    cw_a = {$urandom, $urandom};
    cw_b = {$urandom, $urandom};
    step(1'b1, cw_a, 1'b1, 1'b0, 1'b0);
    step(1'b1, cw_b, 1'b1, 1'b0, 1'b0);
    repeat (29) idle(1'b1);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    check("s5_valid_after_rst", ser_valid, 1'b0);
    check("s5_busy_after_rst", busy, 1'b0);
    check("s5_fcnt_after_rst", frame_cnt, 0);
    repeat (80) idle(1'b1);

    // Single frame, always ready.
    step(1'b1, 64'h8000_0000_0000_0001, 1'b1, 1'b0, 1'b0);
    drain();
    check("s1_fcnt", frame_cnt, 1);
    check("s1_busy", busy, 1'b0);

    // The same frame with random backpressure. Any stall that does not hold
    // the outputs stable shows up as a bit/sof/eof mismatch.
    step(1'b1, 64'h8000_0000_0000_0001, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int n = 0; n < 600 && exp_q.size() != 0; n++) idle(1'($urandom_range(0, 1)));
    drain();
    check("s2_fcnt", frame_cnt, 2);

    // Three captures under full backpressure: the third one is dropped.
    cw_a = {$urandom, $urandom};
    cw_b = {$urandom, $urandom};
    cw_c = {$urandom, $urandom};
    step(1'b1, cw_a, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    step(1'b1, cw_b, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0);
    step(1'b1, cw_c, 1'b0, 1'b0, 1'b0);
    check("s3_overflow", overflow, 1'b1);
    check("s3_busy", busy, 1'b1);
    // ser_valid is checked every cycle, so the two frames must stream
    // without a gap.
    repeat (SYNC_ON ? 144 : 128) idle(1'b1);
    check("s3_fcnt", frame_cnt, 4);
    check("s3_valid_end", ser_valid, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
    check("s3_clr_ovf", overflow, 1'b0);

    // A capture on the last-bit transfer while PR is full is accepted.
    cw_a = {$urandom, $urandom};
    cw_b = {$urandom, $urandom};
    cw_c = {$urandom, $urandom};
    step(1'b1, cw_a, 1'b1, 1'b0, 1'b0);
    step(1'b1, cw_b, 1'b1, 1'b0, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      if (ser_eof) found = 1'b1;
      else idle(1'b1);
    end
    check("s6_eof_seen", found, 1'b1);
    step(1'b1, cw_c, 1'b1, 1'b0, 1'b0);
    check("s6_no_overflow", overflow, 1'b0);
    drain();
    check("s6_fcnt", frame_cnt, 7);

    // Random traffic: captures, backpressure, clears and the occasional reset.
    for (int n = 0; n < 4000; n++) begin
      step(($urandom_range(0, 29) == 0), {$urandom, $urandom},
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 999) == 0));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
